// File: rtl/mac_issue_arbiter.sv
// Issue arbiter for the shared MAC/QUANTIFY datapath. It keeps FC groups atomic,
// bounds CNN starvation and tracks in-flight beats so the core can drain cleanly.
module mac_issue_arbiter #(
    parameter int FC_BEATS      = 3,
    parameter int MAX_FC_GROUPS = 4,
    parameter int PIPE_LAT      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fc_req,
    input  logic       cnn_req,
    input  logic       drain,
    output logic       fc_grant,
    output logic       cnn_grant,
    output logic [1:0] beat_idx,
    output logic       fc_group_done,
    output logic       in_flight,
    output logic       idle
);
    localparam int              RW        = $clog2(MAX_FC_GROUPS + 1);
    localparam logic [1:0]      LAST_BEAT = 2'(FC_BEATS - 1);
    localparam logic [RW-1:0]   RUN_MAX   = RW'(MAX_FC_GROUPS);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GROUP = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          beat_cnt_q, beat_cnt_d;
    logic [RW-1:0]       fc_run_q, fc_run_d;
    logic [PIPE_LAT-1:0] pipe_sr_q, pipe_sr_d;
    logic                fc_group_done_q, fc_group_done_d;
    logic                idle_q, idle_d;
    logic                any_grant;
    logic                last_beat;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            beat_cnt_q      <= '0;
            fc_run_q        <= '0;
            pipe_sr_q       <= '0;
            fc_group_done_q <= 1'b0;
            idle_q          <= 1'b1;
        end else begin
            state_q         <= state_d;
            beat_cnt_q      <= beat_cnt_d;
            fc_run_q        <= fc_run_d;
            pipe_sr_q       <= pipe_sr_d;
            fc_group_done_q <= fc_group_done_d;
            idle_q          <= idle_d;
        end
    end

    // Grants are combinational so the datapath mux sees them alongside the beat data.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        fc_grant  = 1'b0;
        cnn_grant = 1'b0;
        beat_idx  = 2'd0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (!drain) begin
                        if (fc_req && !(fc_run_q == RUN_MAX && cnn_req)) begin
                            fc_grant = 1'b1;
                        end else if (cnn_req) begin
                            cnn_grant = 1'b1;
                        end
                    end
                end
                S_GROUP: begin
                    beat_idx = beat_cnt_q;
                    if (fc_req) begin
                        fc_grant = 1'b1;
                    end else if (cnn_req && !drain) begin
                        cnn_grant = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign any_grant = fc_grant | cnn_grant;
    assign last_beat = fc_grant && (beat_idx == LAST_BEAT);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        fc_run_d   = fc_run_q;
        if (fc_grant) begin
            if (last_beat) begin
                state_d    = S_IDLE;
                beat_cnt_d = 2'd0;
                if (fc_run_q != RUN_MAX) begin
                    fc_run_d = fc_run_q + RW'(1);
                end
            end else begin
                state_d    = S_GROUP;
                beat_cnt_d = beat_idx + 2'd1;
            end
        end else if (cnn_grant && state_q == S_IDLE) begin
            // CNN fill beats inside a group leave the FC run count alone.
            fc_run_d = '0;
        end
        fc_group_done_d = last_beat;
        pipe_sr_d       = {pipe_sr_q[PIPE_LAT-2:0], any_grant};
        idle_d          = (state_q == S_IDLE) && !any_grant && !(|pipe_sr_d);
    end

    assign in_flight     = |pipe_sr_q;
    assign fc_group_done = fc_group_done_q;
    assign idle          = idle_q;
endmodule
